// File: rtl/sci_pkg.sv
// Shared definitions for the SCI request arbiter: controller state encoding
// and a helper that pulls one client's field out of a flattened port bus.
package sci_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_GAP   = 3'd5
  } sci_state_e;

  // Widest flattened bus and widest single field the helper can handle.
  localparam int MAX_FLAT_W  = 256;
  localparam int MAX_SLICE_W = 64;

  // Returns flat[idx*width +: width], zero-extended to MAX_SLICE_W bits.
  function automatic logic [MAX_SLICE_W-1:0] extract_slice(
    input logic [MAX_FLAT_W-1:0] flat,
    input int                    idx,
    input int                    width
  );
    logic [MAX_FLAT_W-1:0] mask;
    logic [MAX_FLAT_W-1:0] shifted;
    mask    = {MAX_FLAT_W{1'b1}} >> (MAX_FLAT_W - width);
    shifted = (flat >> (idx * width)) & mask;
    return shifted[MAX_SLICE_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest asserted request
  // (lowest offset from the pointer) is the one left standing.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sci_arbiter.sv
// Shares one SCI master request port between several local clients.
// Round-robin grant, single-cycle M_REQ edge, held command fields, bounded
// wait with timeout + drain of late ACKs, and an enforced idle gap.
module sci_arbiter #(
  parameter int NUM_REQUESTERS  = 3,
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_PERIPHERALS = 2,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                                  CLK,
  input  logic                                  RSTN,
  input  logic [NUM_REQUESTERS-1:0]             REQ_VALID,
  input  logic [NUM_REQUESTERS-1:0]             REQ_WNR,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0]  REQ_ADDR,
  input  logic [NUM_REQUESTERS*NUM_PERIPHERALS-1:0] REQ_CSN,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]  REQ_WDATA,
  output logic [NUM_REQUESTERS-1:0]             REQ_READY,
  output logic [NUM_REQUESTERS-1:0]             RESP_VALID,
  output logic                                  RESP_ERR,
  output logic [DATA_WIDTH-1:0]                 RESP_RDATA,
  output logic                                  BUSY,
  output logic                                  M_REQ,
  output logic                                  M_WNR,
  output logic [ADDR_WIDTH-1:0]                 M_ADDR,
  output logic [NUM_PERIPHERALS-1:0]            M_CSN,
  output logic [DATA_WIDTH-1:0]                 M_DATA,
  input  logic                                  M_ACK,
  input  logic [DATA_WIDTH-1:0]                 M_RDATA
);

  import sci_pkg::*;

  localparam int IW      = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQUESTERS - 1);

  sci_state_e                state;
  logic [IW-1:0]             rr_ptr;
  logic [CW-1:0]             cnt;
  logic [NUM_REQUESTERS-1:0] owner;
  logic                      timed_out;

  logic [NUM_REQUESTERS-1:0] grant;
  logic [IW-1:0]             grant_idx;
  logic                      grant_any;
  logic [IW-1:0]             next_ptr;

  rr_arbiter #(
    .N  (NUM_REQUESTERS),
    .IW (IW)
  ) u_rr (
    .req       (REQ_VALID),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // Busy is a pure decode of the state register, so it resets low with it.
  assign BUSY = (state != ST_IDLE);

  // Transaction controller: arbitration, issue, wait/timeout, response,
  // drain of a late ACK after a timeout, and the inter-transaction gap.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      owner      <= '0;
      timed_out  <= 1'b0;
      REQ_READY  <= '0;
      RESP_VALID <= '0;
      RESP_ERR   <= 1'b0;
      RESP_RDATA <= '0;
      M_REQ      <= 1'b0;
      M_WNR      <= 1'b0;
      M_ADDR     <= '0;
      M_CSN      <= '1;
      M_DATA     <= '0;
    end else begin
      REQ_READY  <= '0;
      RESP_VALID <= '0;
      M_REQ      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_any) begin
            REQ_READY <= grant;
            owner     <= grant;
            rr_ptr    <= next_ptr;
            M_WNR     <= REQ_WNR[grant_idx];
            M_ADDR    <= ADDR_WIDTH'(extract_slice(MAX_FLAT_W'(REQ_ADDR),
                                                   int'(grant_idx), ADDR_WIDTH));
            M_CSN     <= NUM_PERIPHERALS'(extract_slice(MAX_FLAT_W'(REQ_CSN),
                                                        int'(grant_idx), NUM_PERIPHERALS));
            M_DATA    <= DATA_WIDTH'(extract_slice(MAX_FLAT_W'(REQ_WDATA),
                                                   int'(grant_idx), DATA_WIDTH));
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          M_REQ <= 1'b1;
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (M_ACK) begin
            RESP_VALID <= owner;
            RESP_ERR   <= 1'b0;
            RESP_RDATA <= M_WNR ? '0 : M_RDATA;
            state      <= ST_RESP;
          end else if (cnt == TO_LAST) begin
            RESP_VALID <= owner;
            RESP_ERR   <= 1'b1;
            RESP_RDATA <= '0;
            timed_out  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          RESP_ERR  <= 1'b0;
          M_CSN     <= '1;
          cnt       <= '0;
          timed_out <= 1'b0;
          if (timed_out)            state <= ST_DRAIN;
          else if (GAP_CYCLES == 0) state <= ST_IDLE;
          else                      state <= ST_GAP;
        end
        ST_DRAIN: begin
          if (M_ACK || cnt == TO_LAST) begin
            cnt   <= '0;
            state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sci_arbiter.sv
// Scoreboard bench for sci_arbiter: randomized clients, a behavioural SCI
// master, and a reference model of round-robin grant order and response
// timing derived from the arbitration and timeout rules.
module tb_sci_arbiter;

  localparam int N   = 3;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int NP  = 2;
  localparam int TO  = 256;
  localparam int GAP = 2;

  logic           CLK  = 1'b0;
  logic           RSTN = 1'b0;
  logic [N-1:0]   REQ_VALID;
  logic [N-1:0]   REQ_WNR;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*NP-1:0] REQ_CSN;
  logic [N*DW-1:0] REQ_WDATA;
  logic [N-1:0]   REQ_READY;
  logic [N-1:0]   RESP_VALID;
  logic           RESP_ERR;
  logic [DW-1:0]  RESP_RDATA;
  logic           BUSY;
  logic           M_REQ;
  logic           M_WNR;
  logic [AW-1:0]  M_ADDR;
  logic [NP-1:0]  M_CSN;
  logic [DW-1:0]  M_DATA;
  logic           M_ACK;
  logic [DW-1:0]  M_RDATA;

  always #5 CLK = ~CLK;

  sci_arbiter #(
    .NUM_REQUESTERS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
    .NUM_PERIPHERALS(NP), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ_VALID(REQ_VALID), .REQ_WNR(REQ_WNR),
    .REQ_ADDR(REQ_ADDR), .REQ_CSN(REQ_CSN), .REQ_WDATA(REQ_WDATA),
    .REQ_READY(REQ_READY), .RESP_VALID(RESP_VALID), .RESP_ERR(RESP_ERR),
    .RESP_RDATA(RESP_RDATA), .BUSY(BUSY), .M_REQ(M_REQ), .M_WNR(M_WNR),
    .M_ADDR(M_ADDR), .M_CSN(M_CSN), .M_DATA(M_DATA), .M_ACK(M_ACK),
    .M_RDATA(M_RDATA)
  );

  typedef struct packed {
    logic          wnr;
    logic [AW-1:0] addr;
    logic [NP-1:0] csn;
    logic [DW-1:0] data;
  } issue_t;

  typedef struct {
    int            client;
    logic          err;
    logic [DW-1:0] rdata;
    longint        due;
  } resp_t;

  typedef struct {
    int            lat;
    logic [DW-1:0] rd;
  } lat_t;

  // Client-side command storage
  logic [N-1:0]  valid_q;
  logic          cmd_wnr   [N];
  logic [AW-1:0] cmd_addr  [N];
  logic [NP-1:0] cmd_csn   [N];
  logic [DW-1:0] cmd_wdata [N];
  logic [N-1:0]  busy_c;
  logic [N-1:0]  ready_seen;
  int            auto_left [N];

  // Scoreboard and model state
  issue_t iss_q[$];
  int     iss_client_q[$];
  resp_t  resp_q[$];
  lat_t   lat_q[$];
  int     grant_log[$];
  int     model_ptr;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic [N-1:0] snap;
  longint ack_at;
  logic [DW-1:0] ack_data;
  longint last_end;
  logic   have_last;
  int     mreq_count;
  logic   prev_mreq;
  logic   csn_check_pending;
  logic   hold_active;
  issue_t hold_f;
  longint hold_until;

  // Pack per-client commands onto the flattened request buses
  always_comb begin
    REQ_VALID = valid_q;
    REQ_WNR   = '0;
    REQ_ADDR  = '0;
    REQ_CSN   = '0;
    REQ_WDATA = '0;
    for (int i = 0; i < N; i++) begin
      REQ_WNR[i]             = cmd_wnr[i];
      REQ_ADDR[i*AW +: AW]   = cmd_addr[i];
      REQ_CSN[i*NP +: NP]    = cmd_csn[i];
      REQ_WDATA[i*DW +: DW]  = cmd_wdata[i];
    end
  end

  // Cycle counter and the request vector as the DUT samples it at each edge
  always @(posedge CLK) begin
    cyc  <= cyc + 1;
    snap <= valid_q;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int c, input logic w, input logic [AW-1:0] a,
                               input logic [NP-1:0] cs, input logic [DW-1:0] d);
    cmd_wnr[c]   = w;
    cmd_addr[c]  = a;
    cmd_csn[c]   = cs;
    cmd_wdata[c] = d;
    valid_q[c]   = 1'b1;
    busy_c[c]    = 1'b1;
  endtask

  // Reference rule: first pending client at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] pend, input int ptr);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
    foreach (order[j]) if (pend[order[j]]) return order[j];
    return -1;
  endfunction

  // Reference rule: ACK on cycle t+L (L<TIMEOUT) answers at t+L+1, otherwise
  // the error response lands exactly TIMEOUT cycles after M_REQ.
  function automatic resp_t predict(input int client, input int lat, input logic wnr,
                                    input logic [DW-1:0] rd, input longint t);
    resp_t r;
    r.client = client;
    if (lat >= 1 && lat <= TO - 1) begin
      r.err   = 1'b0;
      r.rdata = wnr ? '0 : rd;
      r.due   = t + lat + 1;
    end else begin
      r.err   = 1'b1;
      r.rdata = '0;
      r.due   = t + TO;
    end
    return r;
  endfunction

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) begin
      case ($urandom_range(0, 4))
        0: return 254;
        1: return 255;
        2: return 256;
        3: return 257;
        default: return -1;
      endcase
    end
    return int'($urandom_range(1, 40));
  endfunction

  function automatic int auto_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += auto_left[i];
    return s;
  endfunction

  task automatic clearBench();
    iss_q.delete();
    iss_client_q.delete();
    resp_q.delete();
    lat_q.delete();
    valid_q           = '0;
    busy_c            = '0;
    ready_seen        = '0;
    for (int i = 0; i < N; i++) auto_left[i] = 0;
    model_ptr         = 0;
    ack_at            = -1;
    have_last         = 1'b0;
    prev_mreq         = 1'b0;
    csn_check_pending = 1'b0;
    hold_active       = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"},  REQ_READY,  0);
    checkOutput({tag, "_resp_valid"}, RESP_VALID, 0);
    checkOutput({tag, "_resp_err"},   RESP_ERR,   0);
    checkOutput({tag, "_resp_rdata"}, RESP_RDATA, 0);
    checkOutput({tag, "_busy"},       BUSY,       0);
    checkOutput({tag, "_m_req"},      M_REQ,      0);
    checkOutput({tag, "_m_wnr"},      M_WNR,      0);
    checkOutput({tag, "_m_addr"},     M_ADDR,     0);
    checkOutput({tag, "_m_csn"},      M_CSN,      2'b11);
    checkOutput({tag, "_m_data"},     M_DATA,     0);
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while ((busy_c != 0 || valid_q != 0 || auto_sum() != 0 || BUSY ||
            resp_q.size() != 0) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: still busy after %0d cycles", name, budget);
    end
    @(posedge CLK);
    #1;
  endtask

  // Behavioural SCI master: drives one ACK pulse on the scheduled cycle and
  // noise on the read-data bus otherwise
  initial begin
    M_ACK   = 1'b0;
    M_RDATA = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (RSTN && ack_at >= 0 && cyc == ack_at) begin
        M_ACK   = 1'b1;
        M_RDATA = ack_data;
      end else begin
        M_ACK   = 1'b0;
        M_RDATA = DW'($urandom);
      end
    end
  end

  // Client engine: drop valid once accepted, reissue random commands on demand
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      for (int c = 0; c < N; c++) begin
        if (valid_q[c] && ready_seen[c]) begin
          valid_q[c]    = 1'b0;
          ready_seen[c] = 1'b0;
        end
        if (RSTN && !busy_c[c] && auto_left[c] > 0) begin
          auto_left[c]--;
          applyStimulus(c, 1'($urandom), AW'($urandom), NP'($urandom), DW'($urandom));
        end
      end
    end
  end

  // Monitor: compares every DUT event against the scoreboard queues
  initial begin
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        prev_mreq = 1'b0;
      end else begin
        if (M_REQ) checkOutput("m_req_single_cycle", M_REQ & prev_mreq, 0);
        if (csn_check_pending) begin
          checkOutput("m_csn_release", M_CSN, 2'b11);
          csn_check_pending = 1'b0;
        end
        if (hold_active && cyc <= hold_until)
          checkOutput("m_fields_held", {M_WNR, M_ADDR, M_CSN, M_DATA}, hold_f);
        if (REQ_READY != 0) begin
          int g;
          g = rr_pick(snap, model_ptr);
          checkOutput("grant", REQ_READY, (g >= 0) ? (64'd1 << g) : 64'd0);
          if (g >= 0) begin
            model_ptr = (g + 1) % N;
            grant_log.push_back(g);
            ready_seen[g] = 1'b1;
            iss_q.push_back('{cmd_wnr[g], cmd_addr[g], cmd_csn[g], cmd_wdata[g]});
            iss_client_q.push_back(g);
          end
        end
        if (M_REQ) begin
          if (iss_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL m_req_unexpected: got M_REQ with no granted command");
          end else begin
            issue_t e;
            int     cl;
            int     lat;
            logic [DW-1:0] rd;
            resp_t  r;
            e  = iss_q.pop_front();
            cl = iss_client_q.pop_front();
            checkOutput("m_fields", {M_WNR, M_ADDR, M_CSN, M_DATA}, e);
            if (have_last)
              checkOutput("gap_cycles", (cyc - last_end - 1) >= GAP, 1);
            if (lat_q.size() != 0) begin
              lat_t l;
              l   = lat_q.pop_front();
              lat = l.lat;
              rd  = l.rd;
            end else begin
              lat = pick_lat();
              rd  = DW'($urandom);
            end
            r = predict(cl, lat, e.wnr, rd, cyc);
            resp_q.push_back(r);
            ack_at      = (lat > 0) ? cyc + lat : -1;
            ack_data    = rd;
            hold_active = 1'b1;
            hold_f      = e;
            hold_until  = r.due;
            mreq_count++;
          end
        end
        if (RESP_VALID != 0) begin
          if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_unexpected: got RESP_VALID=%0b with none pending", RESP_VALID);
          end else begin
            resp_t r;
            r = resp_q.pop_front();
            checkOutput("resp_client", RESP_VALID, 64'd1 << r.client);
            checkOutput("resp_err",    RESP_ERR,   r.err);
            checkOutput("resp_rdata",  RESP_RDATA, r.rdata);
            checkOutput("resp_time",   cyc,        r.due);
            last_end          = r.due - 1;
            have_last         = 1'b1;
            hold_active       = 1'b0;
            csn_check_pending = 1'b1;
            busy_c[r.client]  = 1'b0;
          end
        end
        prev_mreq = M_REQ;
      end
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    int exp_order[6];
    int start_cnt;
    int n;
    exp_order = '{0, 1, 2, 0, 1, 2};
    mreq_count = 0;
    for (int i = 0; i < N; i++) begin
      cmd_wnr[i] = 1'b0; cmd_addr[i] = '0; cmd_csn[i] = '1; cmd_wdata[i] = '0;
    end
    clearBench();
    grant_log.delete();

    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkReset("reset");
    RSTN = 1'b1;
    @(posedge CLK);
    #1;

    $display("[TB] single write from client 1");
    lat_q.push_back('{5, 8'h00});
    applyStimulus(1, 1'b1, 4'hA, 2'b10, 8'h5C);
    waitDone("write", 2000);

    $display("[TB] read from client 0 with 20-cycle master latency");
    lat_q.push_back('{20, 8'hA7});
    applyStimulus(0, 1'b0, 4'h3, 2'b01, 8'h00);
    waitDone("read", 2000);

    $display("[TB] ACK on the last cycle before timeout");
    lat_q.push_back('{255, 8'h3C});
    applyStimulus(1, 1'b0, 4'h7, 2'b01, 8'h11);
    waitDone("collision", 2000);

    $display("[TB] timeout on client 2 with late ACK during drain");
    lat_q.push_back('{300, 8'hEE});
    applyStimulus(2, 1'b0, 4'h5, 2'b10, 8'h00);
    waitDone("timeout", 3000);

    $display("[TB] fairness with all clients requesting");
    grant_log.delete();
    for (int c = 0; c < N; c++) auto_left[c] = 2;
    waitDone("fairness", 8000);
    if (grant_log.size() != 6) begin
      checkOutput("fair_grant_count", grant_log.size(), 6);
    end else begin
      foreach (exp_order[i]) checkOutput($sformatf("fair_order_%0d", i), grant_log[i], exp_order[i]);
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < N; c++) auto_left[c] = int'($urandom_range(1, 3));
    waitDone("random", 30000);

    $display("[TB] reset during WAIT");
    lat_q.push_back('{150, 8'h99});
    start_cnt = mreq_count;
    applyStimulus(1, 1'b1, 4'hC, 2'b01, 8'h42);
    n = 0;
    while (mreq_count == start_cnt && n < 100) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL reset_test_issue: no M_REQ within 100 cycles");
    end
    repeat (10) @(posedge CLK);
    #2;
    RSTN = 1'b0;
    clearBench();
    #1;
    checkReset("async_reset");
    repeat (3) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    @(posedge CLK);
    #1;
    grant_log.delete();
    lat_q.push_back('{6, 8'h21});
    lat_q.push_back('{7, 8'h43});
    applyStimulus(2, 1'b0, 4'h2, 2'b10, 8'h00);
    applyStimulus(1, 1'b0, 4'h9, 2'b01, 8'h00);
    waitDone("post_reset", 2000);
    if (grant_log.size() != 2) begin
      checkOutput("post_reset_grants", grant_log.size(), 2);
    end else begin
      checkOutput("post_reset_first", grant_log[0], 1);
      checkOutput("post_reset_second", grant_log[1], 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sci_arbiter.md
Name: sci_arbiter

Overview:
- Shares one SCI_MASTER request interface between NUM_REQUESTERS local clients (e.g. config FSM, debug bridge, calibration engine).
- Round-robin arbitration; captures the winner's command and issues it to the master as a single-cycle REQ edge.
- Holds the command fields stable until the master ACKs, then routes ACK/read data back to the winner.
- Bounded wait with timeout/error reporting and a programmable inter-transaction gap.

Parameters:
- NUM_REQUESTERS, 3, number of client ports (>=2).
- ADDR_WIDTH, 4, SCI address width; must match the master.
- DATA_WIDTH, 8, SCI data width; must match the master.
- NUM_PERIPHERALS, 2, chip-select width; must match the master.
- TIMEOUT_CYCLES, 256, maximum cycles from M_REQ to M_ACK before error.
- GAP_CYCLES, 2, minimum idle cycles between M_ACK (or timeout) and the next M_REQ.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_REQUESTERS  per-client command valid.
- REQ_WNR  in  NUM_REQUESTERS  per-client 1=write, 0=read.
- REQ_ADDR  in  NUM_REQUESTERS*ADDR_WIDTH  flattened addresses; client i at [i*AW +: AW].
- REQ_CSN  in  NUM_REQUESTERS*NUM_PERIPHERALS  flattened active-low selects.
- REQ_WDATA  in  NUM_REQUESTERS*DATA_WIDTH  flattened write data.
- REQ_READY  out  NUM_REQUESTERS  one-hot, one-cycle command-accept pulse.
- RESP_VALID  out  NUM_REQUESTERS  one-hot, one-cycle completion pulse.
- RESP_ERR  out  1  qualifies RESP_VALID: 1 = timeout.
- RESP_RDATA  out  DATA_WIDTH  read data; valid with RESP_VALID on reads.
- BUSY  out  1  high whenever state != IDLE.
- M_REQ  out  1  to master REQ.
- M_WNR  out  1  to master WNR.
- M_ADDR  out  ADDR_WIDTH  to master ADDR.
- M_CSN  out  NUM_PERIPHERALS  to master CSN_IN.
- M_DATA  out  DATA_WIDTH  to master DATA_IN.
- M_ACK  in  1  from master ACK.
- M_RDATA  in  DATA_WIDTH  from master DATA_OUT.

Behaviour:
- Reset values (async): all outputs 0 except M_CSN = all ones. State IDLE; rr pointer = 0; counters = 0.
- Client rules:
  - Fields must be held stable while REQ_VALID=1 until REQ_READY.
  - Client must not drop REQ_VALID before REQ_READY; dropping it is undefined.
  - The client may issue a new command after its RESP_VALID.
- States and transitions:
  - IDLE:
    - If any REQ_VALID, grant the first asserted index at or after the rr pointer (wrap modulo N).
    - Register that client's WNR/ADDR/CSN/WDATA into the M_* outputs.
    - Pulse REQ_READY[g]; rr pointer <= g+1 (wrap).
    - Go to ISSUE.
  - ISSUE: M_REQ=1 for exactly this cycle; timeout counter cleared; go to WAIT.
  - WAIT:
    - M_* fields held.
    - On M_ACK: capture M_RDATA, go to RESP.
    - Else when counter reaches TIMEOUT_CYCLES-1: go to RESP with error flag.
  - RESP:
    - RESP_VALID[g]=1 for one cycle, with RESP_ERR and RESP_RDATA valid.
    - M_CSN <= all ones.
    - Normal completion -> GAP. Timeout -> DRAIN.
  - DRAIN: wait for a late M_ACK (discarded, no RESP) or a further TIMEOUT_CYCLES, then go to GAP.
  - GAP: count GAP_CYCLES, then go to IDLE. GAP_CYCLES=0 goes straight to IDLE.
- Latency: REQ_VALID sampled in IDLE -> REQ_READY the same edge's registered cycle (+1) -> M_REQ +2.
- Minimum transaction period: 4 + GAP_CYCLES + master latency.
- M_REQ is never high on two consecutive cycles, so the master's rise-edge detector always fires.
- RESP_RDATA holds its last captured value between responses. It is 0 on writes and on timeout.
- Simultaneous events:
  - M_ACK on the same cycle the timeout expires: ACK wins, no error.
  - M_ACK outside WAIT/DRAIN is ignored.
  - New REQ_VALIDs during non-IDLE states wait; no starvation (rr guarantees service within N grants).
- Reset mid-transaction: immediate return to IDLE. Outstanding client gets no RESP. M_CSN forced all ones.

Decomposition:
- Package sci_pkg: state encoding (IDLE, ISSUE, WAIT, RESP, DRAIN, GAP) and a function for flattened-slice extraction.
- One natural sub-module, rr_arbiter: request vector + pointer in, one-hot grant + index out, combinational, parameterised by N.

Test Plan:
- Single write: client 1 requests WNR=1, ADDR=4'hA, CSN=2'b10, WDATA=8'h5C.
  - Response: REQ_READY=3'b010, then a single M_REQ pulse with those M_* values held until M_ACK.
  - Then RESP_VALID=3'b010, RESP_ERR=0.
- Read: client 0 reads ADDR=4'h3; model returns M_RDATA=8'hA7 with M_ACK 20 cycles later.
  - Response: RESP_VALID=3'b001, RESP_RDATA=8'hA7.
- Fairness: all three clients hold REQ_VALID continuously for 6 transactions.
  - Response: grant order 0,1,2,0,1,2.
  - Each M_REQ separated by >= GAP_CYCLES idle cycles after the previous ACK.
- Timeout: client 2 request, M_ACK never asserted.
  - Response: RESP_VALID=3'b100 with RESP_ERR=1 exactly 256 cycles after M_REQ.
  - A late M_ACK in DRAIN produces no RESP.
- ACK/timeout collision: M_ACK on cycle 255 after M_REQ -> RESP_ERR=0, data captured.
- Reset mid-WAIT: RSTN low during WAIT.
  - Response: all outputs at reset values asynchronously, M_CSN=2'b11.
  - After release, a new request is served normally with rr pointer 0.
